helen_nios_1_cpu_debug_ocimem: RTL and testbench
================================================

# helen_nios_1_cpu_debug_ocimem

Sysclk-domain consumer of the Nios II debug slave command strobes: decodes the OCI-memory actions (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`) and the 38-bit `jdo` payload into word reads and writes on an Avalon-MM master port into the debug memory. It returns `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the JTAG debug slave's readback path, closing the host-memory-access loop.

## Interface
- `ADDR_W`, 9, word-address width (512 words); byte address is `{addr, 2'b00}`.
- `TIMEOUT`, 255, max consecutive `avm_waitrequest` cycles before abort (8-bit counter, 1..255).
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset; synchronous, active-low.
- `jdo`  in  38  command payload from debug slave sysclk stage.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address / optional read.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write data, post-increment.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: read, post-increment.
- `avm_address`  out  ADDR_W+2  byte address.
- `avm_read`, `avm_write`  out  1  request; held until `avm_waitrequest`=0.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  valid in the cycle a read completes.
- `avm_waitrequest`  in  1  slave stall.
- `MonDReg`  out  32  last read data.
- `monitor_ready`  out  1  1 = idle, accepting commands.
- `monitor_error`  out  1  sticky error.

## Operation
- Field decode: `jdo[25:17]` address (low ADDR_W bits used); `jdo[34]` read-after-load; `jdo[35]` clear error; `jdo[34:3]` write data.
- Strobe priority when simultaneous: `ocimem_a` > `ocimem_b` > `no_action_ocimem_a`; lower ones dropped, no error.
- States: IDLE, RD, WR.
- IDLE + `ocimem_a`: addr <= `jdo[25:17]`; if `jdo[35]` error <= 0; if `jdo[34]` -> RD (no post-increment), else stay IDLE.
- IDLE + `ocimem_b`: writedata <= `jdo[34:3]` -> WR (post-increment).
- IDLE + `no_action_ocimem_a` -> RD (post-increment).
- RD/WR: request held; on sampled `avm_waitrequest`=0 -> IDLE; RD captures `avm_readdata` into `MonDReg`; addr += 1 if post-increment flagged, wrapping 2^ADDR_W-1 -> 0.
- Any strobe while in RD/WR: ignored, `monitor_error` <= 1; transaction continues.
- Reset values: `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `avm_read`=`avm_write`=0, `avm_address`=0, `avm_writedata`=0, state IDLE.
- Reset asserted mid-transaction: next edge forces reset values, request dropped, no address increment, no data capture.

## Timing
- Strobe at edge N -> `avm_read`/`avm_write` high and `monitor_ready` low from N+1.
- Zero-wait slave: completion sampled at N+1; `MonDReg`, address, `monitor_ready`=1 updated at N+2 (2-cycle command-to-ready).
- Each waitrequest cycle adds one cycle of latency.
- Back-to-back: next strobe accepted in the cycle `monitor_ready` is high.
- `avm_address`/`avm_writedata` stable for the entire request.

## Configuration
- `HELEN_NIOS_1_OCIMEM_TIMEOUT_EN` defined: counter increments each RD/WR cycle with `avm_waitrequest`=1 and clears on entry. When waitrequest is still high on the TIMEOUT-th such cycle, the request drops at the next edge with `monitor_error`<=1 and `monitor_ready`<=1; `MonDReg` and address are unchanged.
- Undefined: no counter; waits indefinitely; error sources limited to busy collisions.

## Test plan
- Load `jdo[25:17]`=0x010, `jdo[34]`=1, slave returns 0xDEADBEEF with zero wait -> `avm_address`=0x040, `avm_read` high 1 cycle, `MonDReg`=0xDEADBEEF at N+2, address stays 0x010.
- Three `ocimem_b` writes of 1,2,3 after load 0x1FE -> writes at byte addresses 0x7F8, 0x7FC, 0x000 (wrap), final address 0x001.
- `avm_waitrequest` held 3 cycles on read -> `monitor_ready` low 4 cycles, single read completion, no error.
- Strobe during an active write -> `monitor_error`=1, write completes once; later load with `jdo[35]`=1 -> error clears.
- With timeout enabled and TIMEOUT=4, waitrequest stuck high -> `avm_read` drops after the 4th stall cycle, `monitor_error`=1, `MonDReg` unchanged; without macro -> request held 1000 cycles.
- `reset_n`=0 for one edge mid-read -> all outputs at reset values next cycle, `monitor_ready`=1, no capture.

Source files
------------

// File: rtl/helen_nios_1_cpu_debug_ocimem_if.sv
// helen_nios_1_cpu_debug_ocimem_if: Avalon-MM word link from the OCI-memory engine into debug memory.
interface helen_nios_1_cpu_debug_ocimem_if #(parameter int ADDR_W = 9);
    logic [ADDR_W+1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    modport master(output address, read, write, writedata, input readdata, waitrequest);
    modport slave(input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/helen_nios_1_cpu_debug_ocimem.sv
// helen_nios_1_cpu_debug_ocimem: turns debug-slave OCI-memory strobes into Avalon word reads/writes.
// Optional stall abort is built when HELEN_NIOS_1_OCIMEM_TIMEOUT_EN is defined.
module helen_nios_1_cpu_debug_ocimem #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [37:0]                     jdo,
    input  logic                            take_action_ocimem_a,
    input  logic                            take_action_ocimem_b,
    input  logic                            take_no_action_ocimem_a,
    helen_nios_1_cpu_debug_ocimem_if.master avm,
    output logic [31:0]                     MonDReg,
    output logic                            monitor_ready,
    output logic                            monitor_error
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [31:0]       wdata, wdata_n, mon_n;
    logic              err_n, inc, inc_n;
    logic              unused;
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt, cnt_n;
`endif
    assign avm.address   = {addr, 2'b00};
    assign avm.read      = state == RD;
    assign avm.write     = state == WR;
    assign avm.writedata = wdata;
    assign monitor_ready = state == IDLE;
    assign unused        = ^{jdo[37:36], jdo[2:0], TIMEOUT[0]};
    always_comb begin
        state_n = state;
        addr_n  = addr;
        wdata_n = wdata;
        mon_n   = MonDReg;
        err_n   = monitor_error;
        inc_n   = inc;
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
        cnt_n   = '0;
`endif
        if (state == IDLE) begin
            if (take_action_ocimem_a) begin
                addr_n = jdo[17 +: ADDR_W];
                if (jdo[35]) err_n = 1'b0;
                if (jdo[34]) begin
                    state_n = RD;
                    inc_n   = 1'b0;
                end
            end else if (take_action_ocimem_b) begin
                wdata_n = jdo[34:3];
                state_n = WR;
                inc_n   = 1'b1;
            end else if (take_no_action_ocimem_a) begin
                state_n = RD;
                inc_n   = 1'b1;
            end
        end else begin
            // a busy engine cannot queue commands, so any strobe is a host protocol error
            if (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a) err_n = 1'b1;
            if (!avm.waitrequest) begin
                state_n = IDLE;
                if (state == RD) mon_n = avm.readdata;
                if (inc) addr_n = addr + 1'b1;
            end
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
            else if (cnt == LAST) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else cnt_n = cnt + 8'd1;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            wdata         <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
            inc           <= 1'b0;
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            wdata         <= wdata_n;
            MonDReg       <= mon_n;
            monitor_error <= err_n;
            inc           <= inc_n;
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
            cnt           <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_helen_nios_1_cpu_debug_ocimem.sv
// tb_helen_nios_1_cpu_debug_ocimem: directed bench with a transaction-level model and a per-cycle compare.
module tb_helen_nios_1_cpu_debug_ocimem;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [37:0] jdo = '0;
    logic        sa = 0, sb = 0, sn = 0;
    logic [31:0] mon;
    logic        ready, err;
    int          total = 0, bad = 0;
    int          rd_high = 0, ready_low = 0, rd_done = 0;
    int          wait_cfg = 0, sl_cnt = 0;
    bit          stuck = 0, chk_on = 0;
    logic [31:0] mem [512];
    int          wa[$];
    logic [31:0] wd[$];
    bit          m_busy = 0, m_isrd = 0, m_inc = 0, m_err = 0;
    int          m_addr = 0, m_stalls = 0;
    logic [31:0] m_wdata = 0, m_mon = 0;

    helen_nios_1_cpu_debug_ocimem_if #(.ADDR_W(9)) avm();
    helen_nios_1_cpu_debug_ocimem #(.ADDR_W(9), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(sa), .take_action_ocimem_b(sb), .take_no_action_ocimem_a(sn),
        .avm(avm.master), .MonDReg(mon), .monitor_ready(ready), .monitor_error(err));

    always #5 clk = ~clk;
    assign avm.waitrequest = stuck || (sl_cnt < wait_cfg);
    assign avm.readdata    = mem[avm.address[10:2]];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    // model of the command engine, plus the bench's memory slave
    always @(posedge clk) begin
        bit wq;
        logic [31:0] rdv;
        wq  = avm.waitrequest;
        rdv = avm.readdata;
        if (avm.read) rd_high++;
        if (!ready) ready_low++;
        if (avm.read && !wq) rd_done++;
        if (avm.write && !wq) begin
            wa.push_back(int'(avm.address));
            wd.push_back(avm.writedata);
            mem[avm.address[10:2]] = avm.writedata;
        end
        if (!reset_n) begin
            m_busy = 0; m_isrd = 0; m_inc = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_mon = 0;
        end else if (!m_busy) begin
            m_stalls = 0;
            if (sa) begin
                m_addr = int'(jdo[25:17]);
                if (jdo[35]) m_err = 0;
                if (jdo[34]) begin m_busy = 1; m_isrd = 1; m_inc = 0; end
            end else if (sb) begin
                m_wdata = jdo[34:3]; m_busy = 1; m_isrd = 0; m_inc = 1;
            end else if (sn) begin
                m_busy = 1; m_isrd = 1; m_inc = 1;
            end
        end else begin
            if (sa || sb || sn) m_err = 1;
            if (!wq) begin
                if (m_isrd) m_mon = rdv;
                if (m_inc) m_addr = (m_addr + 1) % 512;
                m_busy = 0;
            end else begin
                m_stalls++;
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
                if (m_stalls == 4) begin m_busy = 0; m_err = 1; end
`endif
            end
        end
        if ((avm.read || avm.write) && wq) sl_cnt++;
        else sl_cnt = 0;
    end

    always @(negedge clk) if (chk_on) begin
        chk("read", avm.read, m_busy && m_isrd);
        chk("write", avm.write, m_busy && !m_isrd);
        chk("ready", ready, !m_busy);
        chk("address", avm.address, m_addr * 4);
        chk("writedata", avm.writedata, m_wdata);
        chk("mondreg", mon, m_mon);
        chk("error", err, m_err);
    end

    function automatic logic [37:0] ld(input int a, input bit rd, input bit clr);
        return (38'(clr) << 35) | (38'(rd) << 34) | (38'(a) << 17);
    endfunction
    function automatic logic [37:0] wrj(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic cmd(input logic [2:0] k, input logic [37:0] d);
        @(negedge clk);
        jdo = d; sa = k[2]; sb = k[1]; sn = k[0];
        @(negedge clk);
        sa = 0; sb = 0; sn = 0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!ready && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", ready, 1);
    endtask

    initial begin
        int r0, d0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_ready", ready, 1);
        chk("rst_mon", mon, 0);
        chk("rst_addr", avm.address, 0);
        reset_n = 1;

        mem[16] = 32'hDEADBEEF;
        r0 = rd_high;
        cmd(3'b100, ld(16, 1, 0));
        chk("t1_addr", avm.address, 11'h040);
        chk("t1_read", avm.read, 1);
        @(negedge clk);
        chk("t1_mon", mon, 32'hDEADBEEF);
        chk("t1_ready", ready, 1);
        chk("t1_addr_kept", avm.address, 11'h040);
        chk("t1_rd_cycles", rd_high - r0, 1);

        cmd(3'b100, ld(9'h1FE, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            cmd(3'b010, wrj(32'(i)));
            wait_idle(10);
        end
        chk("t2_nwr", wa.size(), 3);
        chk("t2_a0", wa[0], 11'h7F8);
        chk("t2_a1", wa[1], 11'h7FC);
        chk("t2_a2", wa[2], 11'h000);
        chk("t2_d2", wd[2], 3);
        chk("t2_final", avm.address, 11'h004);

        wait_cfg = 3;
        mem[5] = 32'h12345678;
        cmd(3'b100, ld(5, 0, 0));
        ready_low = 0;
        d0 = rd_done;
        cmd(3'b100, ld(5, 1, 0));
        wait_idle(20);
        chk("t3_ready_low", ready_low, 4);
        chk("t3_done", rd_done - d0, 1);
        chk("t3_mon", mon, 32'h12345678);
        chk("t3_err", err, 0);

        wait_cfg = 2;
        cmd(3'b010, wrj(32'hAA));
        cmd(3'b001, '0);
        wait_idle(20);
        chk("t4_err", err, 1);
        chk("t4_nwr", wa.size(), 4);
        cmd(3'b100, ld(0, 0, 1));
        chk("t4_clear", err, 0);

        wait_cfg = 0;
        mem[7] = 32'h77;
        cmd(3'b111, ld(7, 1, 0));
        wait_idle(10);
        chk("prio_mon", mon, 32'h77);
        chk("prio_err", err, 0);
        chk("prio_addr", avm.address, 11'h01C);

        stuck = 1;
        r0 = rd_high;
        cmd(3'b001, '0);
`ifdef HELEN_NIOS_1_OCIMEM_TIMEOUT_EN
        wait_idle(20);
        chk("tmo_rd_cycles", rd_high - r0, 4);
        chk("tmo_err", err, 1);
        chk("tmo_mon", mon, 32'h77);
        chk("tmo_addr", avm.address, 11'h01C);
        stuck = 0;
`else
        repeat (1000) @(negedge clk);
        chk("hold_read", avm.read, 1);
        chk("hold_ready", ready, 0);
        stuck = 0;
        wait_idle(10);
`endif

        wait_cfg = 2;
        mem[9] = 32'hCAFEF00D;
        cmd(3'b100, ld(9, 1, 0));
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        chk("rst_mid_read", avm.read, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_mon", mon, 0);
        chk("rst_mid_addr", avm.address, 0);
        chk("rst_mid_err", err, 0);
        wait_cfg = 0;
        cmd(3'b100, ld(9, 1, 1));
        wait_idle(10);
        chk("post_rst_mon", mon, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
